// File: rtl/byte_fifo_fwft.sv
// Byte-wide first-word-fall-through FIFO with occupancy and flush.
// Shared by the external-bus byte sink and the USB endpoint buffers.
module byte_fifo_fwft #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            head_data,
  output logic                  head_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                empty;
  logic                do_push;
  logic                do_pop;

  // One extra pointer bit tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_valid = ~empty;
  assign head_data  = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ext_bus_byte_sink.sv
// Target-side responder for the external byte-write bus: DATA pushes into a
// FIFO drained as a valid/ready byte stream; CTRL gives flush/enable/drop-clear.
module ext_bus_byte_sink #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] DATA_ADDR  = 16'h0000,
  parameter logic [15:0] CTRL_ADDR  = 16'h0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           i_ext_addr,
  input  logic [7:0]            i_ext_data,
  input  logic                  i_ext_wstrb,
  input  logic                  i_ext_valid,
  output logic                  o_ext_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_enabled,
  output logic                  o_dropped
);

  logic is_data;
  logic is_ctrl;
  logic full;
  logic accept;
  logic done;
  logic push;
  logic pop;
  logic flush;

  assign is_data = i_ext_wstrb & (i_ext_addr == DATA_ADDR);
  assign is_ctrl = i_ext_wstrb & (i_ext_addr == CTRL_ADDR);

  // Only a DATA push into a full FIFO stalls; a disabled sink drops instead.
  assign o_ext_ready = ~(is_data & full & o_enabled);

  assign accept = i_ext_valid & o_ext_ready & ~done;
  assign push   = accept & is_data & o_enabled;
  assign flush  = accept & is_ctrl & i_ext_data[0];
  assign pop    = o_tx_valid & i_tx_ready;

  // The SoC holds valid one cycle past the handshake; done masks the repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else if (!i_ext_valid) begin
      done <= 1'b0;
    end else if (accept) begin
      done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_enabled <= 1'b1;
      o_dropped <= 1'b0;
    end else if (accept && is_ctrl) begin
      o_enabled <= i_ext_data[1];
      if (i_ext_data[2]) o_dropped <= 1'b0;
    end else if (accept && is_data && !o_enabled) begin
      o_dropped <= 1'b1;
    end
  end

  byte_fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (i_ext_data),
    .pop        (pop),
    .flush      (flush),
    .head_data  (o_tx_data),
    .head_valid (o_tx_valid),
    .full       (full),
    .level      (o_level)
  );

endmodule

// File: tb/tb_ext_bus_byte_sink.sv
// Scoreboard bench for ext_bus_byte_sink: bus writes push expected bytes,
// every stream handshake pops and compares the head of the queue.
module tb_ext_bus_byte_sink;

  localparam int DEPTH_LOG2 = 2;
  localparam logic [15:0] DATA_ADDR = 16'h0000;
  localparam logic [15:0] CTRL_ADDR = 16'h0001;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [15:0]         i_ext_addr = '0;
  logic [7:0]          i_ext_data = '0;
  logic                i_ext_wstrb = 1'b0;
  logic                i_ext_valid = 1'b0;
  logic                o_ext_ready;
  logic [7:0]          o_tx_data;
  logic                o_tx_valid;
  logic                i_tx_ready = 1'b0;
  logic [DEPTH_LOG2:0] o_level;
  logic                o_enabled;
  logic                o_dropped;

  int checks = 0;
  int passed = 0;
  int n_popped = 0;
  int max_level = 0;
  bit rand_mode = 1'b0;
  logic [7:0] exp_q [$];

  logic [DEPTH_LOG2:0] snap_level;
  logic                snap_tvalid;
  logic [7:0]          snap_tdata;
  logic                snap_ready;
  logic                snap_en;
  logic                snap_drop;

  always #5 clk = ~clk;

  ext_bus_byte_sink #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_ADDR  (DATA_ADDR),
    .CTRL_ADDR  (CTRL_ADDR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ext_addr  (i_ext_addr),
    .i_ext_data  (i_ext_data),
    .i_ext_wstrb (i_ext_wstrb),
    .i_ext_valid (i_ext_valid),
    .o_ext_ready (o_ext_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_level     (o_level),
    .o_enabled   (o_enabled),
    .o_dropped   (o_dropped)
  );

  // Snapshot outputs at the falling edge, score any stream handshake, then
  // advance past the next rising edge and land 1 time unit after it.
  task automatic tick();
    logic [7:0] exp_byte;
    @(negedge clk);
    snap_level  = o_level;
    snap_tvalid = o_tx_valid;
    snap_tdata  = o_tx_data;
    snap_ready  = o_ext_ready;
    snap_en     = o_enabled;
    snap_drop   = o_dropped;
    if (int'(o_level) > max_level) max_level = int'(o_level);
    if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL stream_unexpected: got byte %02h, expected no byte", o_tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (o_tx_data !== exp_byte)
          $display("[TB] FAIL stream_data: got %02h, expected %02h", o_tx_data, exp_byte);
        else
          passed++;
      end
      n_popped++;
    end
    @(posedge clk);
    #1;
    if (rand_mode) i_tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic bus_start(input logic [15:0] a, input logic [7:0] d, input logic w);
    tick();
    i_ext_addr  = a;
    i_ext_data  = d;
    i_ext_wstrb = w;
    i_ext_valid = 1'b1;
  endtask

  // Wait for ready, then hold valid one more cycle like the SoC does.
  // On return the snapshot holds the state right after the accepting edge.
  task automatic bus_finish(output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      tick();
      if (snap_ready === 1'b1) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL bus_accept_timeout: got no ready after %0d cycles, expected ready", waited);
    end else begin
      tick();
    end
    i_ext_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic w,
                           output int waited);
    bus_start(a, d, w);
    bus_finish(waited);
  endtask

  task automatic drain(input int n);
    i_tx_ready = 1'b1;
    repeat (n) tick();
    i_tx_ready = 1'b0;
    tick();
    checks++;
    if (snap_level !== '0)
      $display("[TB] FAIL drain_level: got %0d, expected 0", snap_level);
    else passed++;
    checks++;
    if (exp_q.size() != 0)
      $display("[TB] FAIL drain_missing: got %0d bytes undelivered, expected 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (snap_level !== '0) $display("[TB] FAIL reset_level: got %0d, expected 0", snap_level);
    else passed++;
    checks++;
    if (snap_tvalid !== 1'b0) $display("[TB] FAIL reset_tx_valid: got %b, expected 0", snap_tvalid);
    else passed++;
    checks++;
    if (snap_tdata !== 8'h00) $display("[TB] FAIL reset_tx_data: got %02h, expected 00", snap_tdata);
    else passed++;
    checks++;
    if (snap_en !== 1'b1 || snap_drop !== 1'b0)
      $display("[TB] FAIL reset_ctrl: got en=%b drop=%b, expected en=1 drop=0", snap_en, snap_drop);
    else passed++;
    checks++;
    if (snap_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b, expected 1", snap_ready);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w;
    int n0;
    n0 = n_popped;
    i_tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    bus_write(DATA_ADDR, 8'h41, 1'b1, w);
    checks++;
    if (snap_level !== 3'd1 || snap_tvalid !== 1'b1 || snap_tdata !== 8'h41)
      $display("[TB] FAIL basic_latency: got level=%0d valid=%b data=%02h, expected level=1 valid=1 data=41",
               snap_level, snap_tvalid, snap_tdata);
    else passed++;
    tick();
    checks++;
    if (snap_level !== '0 || snap_tvalid !== 1'b0)
      $display("[TB] FAIL basic_drained: got level=%0d valid=%b, expected level=0 valid=0", snap_level, snap_tvalid);
    else passed++;
    repeat (3) tick();
    i_tx_ready = 1'b0;
    checks++;
    if (n_popped - n0 != 1) $display("[TB] FAIL basic_count: got %0d bytes, expected 1", n_popped - n0);
    else passed++;
  endtask

  task automatic test_duplicate();
    i_tx_ready = 1'b0;
    exp_q.push_back(8'h55);
    bus_start(DATA_ADDR, 8'h55, 1'b1);
    repeat (3) tick();
    i_ext_valid = 1'b0;
    tick();
    checks++;
    if (snap_level !== 3'd1) $display("[TB] FAIL duplicate_level: got %0d, expected 1", snap_level);
    else passed++;
    drain(4);
  endtask

  task automatic test_full_backpressure();
    int w;
    i_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(i));
      bus_write(DATA_ADDR, 8'(i), 1'b1, w);
    end
    tick();
    checks++;
    if (snap_level !== 3'd4) $display("[TB] FAIL full_level: got %0d, expected 4", snap_level);
    else passed++;
    exp_q.push_back(8'h04);
    bus_start(DATA_ADDR, 8'h04, 1'b1);
    tick();
    checks++;
    if (snap_ready !== 1'b0) $display("[TB] FAIL full_stall: got ready=%b, expected 0", snap_ready);
    else passed++;
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    bus_finish(w);
    checks++;
    if (w != 0) $display("[TB] FAIL full_release: got %0d extra stall cycles, expected 0", w);
    else passed++;
    checks++;
    if (snap_level !== 3'd4) $display("[TB] FAIL full_refill: got level %0d, expected 4", snap_level);
    else passed++;
    drain(6);
  endtask

  task automatic test_wrap();
    int w;
    int n0;
    n0 = n_popped;
    max_level = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 37; i++) begin
      exp_q.push_back(8'(i + 32));
      bus_write(DATA_ADDR, 8'(i + 32), 1'b1, w);
    end
    rand_mode = 1'b0;
    drain(12);
    checks++;
    if (n_popped - n0 != 37) $display("[TB] FAIL wrap_count: got %0d bytes, expected 37", n_popped - n0);
    else passed++;
    checks++;
    if (max_level > 4) $display("[TB] FAIL wrap_max_level: got %0d, expected <= 4", max_level);
    else passed++;
  endtask

  task automatic test_ctrl();
    int w;
    i_tx_ready = 1'b0;
    bus_write(CTRL_ADDR, 8'h00, 1'b1, w);
    tick();
    checks++;
    if (snap_en !== 1'b0) $display("[TB] FAIL ctrl_disable: got en=%b, expected 0", snap_en);
    else passed++;
    bus_write(DATA_ADDR, 8'h99, 1'b1, w);
    checks++;
    if (w != 0) $display("[TB] FAIL ctrl_drop_ready: got %0d stall cycles, expected 0", w);
    else passed++;
    tick();
    checks++;
    if (snap_drop !== 1'b1 || snap_level !== '0)
      $display("[TB] FAIL ctrl_dropped: got drop=%b level=%0d, expected drop=1 level=0", snap_drop, snap_level);
    else passed++;
    bus_write(CTRL_ADDR, 8'h06, 1'b1, w);
    tick();
    checks++;
    if (snap_en !== 1'b1 || snap_drop !== 1'b0)
      $display("[TB] FAIL ctrl_enable_clear: got en=%b drop=%b, expected en=1 drop=0", snap_en, snap_drop);
    else passed++;
    for (int i = 0; i < 3; i++) bus_write(DATA_ADDR, 8'(8'hA1 + i), 1'b1, w);
    tick();
    checks++;
    if (snap_level !== 3'd3) $display("[TB] FAIL ctrl_queued: got level %0d, expected 3", snap_level);
    else passed++;
    bus_write(CTRL_ADDR, 8'h03, 1'b1, w);
    checks++;
    if (snap_level !== '0 || snap_tvalid !== 1'b0)
      $display("[TB] FAIL ctrl_flush: got level=%0d valid=%b, expected level=0 valid=0", snap_level, snap_tvalid);
    else passed++;
    tick();
    checks++;
    if (snap_en !== 1'b1) $display("[TB] FAIL ctrl_flush_en: got en=%b, expected 1", snap_en);
    else passed++;
  endtask

  task automatic test_ignored();
    int w;
    int wa;
    i_tx_ready = 1'b0;
    exp_q.push_back(8'h5A);
    bus_write(DATA_ADDR, 8'h5A, 1'b1, w);
    bus_write(DATA_ADDR, 8'hEE, 1'b0, w);
    bus_write(16'h0007, 8'h00, 1'b1, wa);
    checks++;
    if (w != 0 || wa != 0) $display("[TB] FAIL ignored_ready: got stalls %0d/%0d, expected 0/0", w, wa);
    else passed++;
    tick();
    checks++;
    if (snap_level !== 3'd1 || snap_tdata !== 8'h5A || snap_en !== 1'b1 || snap_drop !== 1'b0)
      $display("[TB] FAIL ignored_state: got level=%0d data=%02h en=%b drop=%b, expected 1 5a 1 0",
               snap_level, snap_tdata, snap_en, snap_drop);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int w;
    bus_write(CTRL_ADDR, 8'h00, 1'b1, w);
    bus_start(DATA_ADDR, 8'h77, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h77);
    tick();
    checks++;
    if (snap_level !== '0 || snap_tvalid !== 1'b0 || snap_tdata !== 8'h00 ||
        snap_en !== 1'b1 || snap_drop !== 1'b0)
      $display("[TB] FAIL midreset_state: got level=%0d valid=%b data=%02h en=%b drop=%b, expected 0 0 00 1 0",
               snap_level, snap_tvalid, snap_tdata, snap_en, snap_drop);
    else passed++;
    tick();
    i_ext_valid = 1'b0;
    checks++;
    if (snap_level !== 3'd1 || snap_tdata !== 8'h77)
      $display("[TB] FAIL midreset_new_txn: got level=%0d data=%02h, expected level=1 data=77", snap_level, snap_tdata);
    else passed++;
    drain(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_full_backpressure();
    test_wrap();
    test_ctrl();
    test_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
